hermes_periph_port: RTL

// - Attaches N_PERIPH packet peripherals (task injectors, IO devices) to one Hermes mesh edge port.
// - Egress: round-robin, packet-atomic arbitration of peripheral packets onto the port.
// - Ingress: demux of port packets to one peripheral by a header index field.
// - Optional per-peripheral gating by the PE release signal.

---
 rtl/hermes_periph_port.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/hermes_periph_port.sv
// Hermes mesh edge port shared by N_PERIPH packet peripherals: round-robin packet-atomic egress, header-indexed ingress demux.
// Optional statistics counters are built when PERIPH_PORT_STATS_EN is defined.
module hermes_periph_port #(
  parameter int                  FLIT_SIZE    = 32,
  parameter int                  N_PERIPH     = 2,
  parameter logic [N_PERIPH-1:0] RELEASE_MASK = '0,
  parameter int                  SIZE_W       = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          release_i,
  input  logic [N_PERIPH-1:0]           per_rx_i,
  output logic [N_PERIPH-1:0]           per_credit_o,
  input  logic [N_PERIPH*FLIT_SIZE-1:0] per_data_i,
  output logic [N_PERIPH-1:0]           per_tx_o,
  input  logic [N_PERIPH-1:0]           per_credit_i,
  output logic [N_PERIPH*FLIT_SIZE-1:0] per_data_o,
  output logic                          noc_tx_o,
  input  logic                          noc_credit_i,
  output logic [FLIT_SIZE-1:0]          noc_data_o,
  input  logic                          noc_rx_i,
  output logic                          noc_credit_o,
  input  logic [FLIT_SIZE-1:0]          noc_data_i,
  output logic [1:0]                    egress_state_o,
  output logic [1:0]                    ingress_state_o
`ifdef PERIPH_PORT_STATS_EN
  ,
  output logic [N_PERIPH*16-1:0]        egress_pkts_o,
  output logic [15:0]                   drop_pkts_o
`endif
);

  // Handshake: a flit moves in any cycle where its valid and the receiver's credit are both high.
  localparam int GW    = (N_PERIPH > 1) ? $clog2(N_PERIPH) : 1;
  // One guard bit above the index width so out-of-range targets are recognisable.
  localparam int IDX_W = $clog2(N_PERIPH) + 1;
  localparam logic [IDX_W-1:0] NP_IDX = IDX_W'(N_PERIPH);

  typedef enum logic [1:0] {E_ARB, E_HDR, E_SIZE, E_PAY} e_state_t;
  typedef enum logic [1:0] {I_HDR, I_SIZE, I_PAY} i_state_t;

  e_state_t          r_e_state;
  logic [GW-1:0]     r_grant;
  logic [GW-1:0]     r_last;
  logic [SIZE_W-1:0] r_e_cnt;
  i_state_t          r_i_state;
  logic [GW-1:0]     r_tgt;
  logic              r_drop;
  logic [SIZE_W-1:0] r_i_cnt;

  logic [N_PERIPH-1:0]  w_en;
  logic [N_PERIPH-1:0]  w_req;
  logic                 w_arb_found;
  logic [GW-1:0]        w_arb_idx;
  logic [GW-1:0]        w_cand;
  logic                 w_e_busy;
  logic [FLIT_SIZE-1:0] w_e_flit;
  logic                 w_e_xfer;
  logic                 w_e_end;
  logic [IDX_W-1:0]     w_hdr_t;
  logic [GW-1:0]        w_hdr_tgt;
  logic                 w_hdr_valid;
  logic [N_PERIPH-1:0]  w_i_sel;
  logic                 w_i_xfer;
  logic                 w_i_end;

  assign w_en  = ~RELEASE_MASK | {N_PERIPH{release_i}};
  assign w_req = per_rx_i & w_en;

  // Scan downwards so the candidate closest above r_last is the one that sticks.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    w_cand      = '0;
    for (int k = N_PERIPH; k >= 1; k--) begin
      w_cand = GW'((int'(r_last) + k) % N_PERIPH);
      if (w_req[w_cand]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = w_cand;
      end
    end
  end

  assign w_e_busy   = (r_e_state != E_ARB);
  assign w_e_flit   = per_data_i[r_grant*FLIT_SIZE +: FLIT_SIZE];
  assign noc_tx_o   = w_e_busy & per_rx_i[r_grant];
  assign noc_data_o = w_e_busy ? w_e_flit : '0;
  assign w_e_xfer   = noc_tx_o & noc_credit_i;
  assign w_e_end    = w_e_xfer &&
                      (((r_e_state == E_SIZE) && (w_e_flit[SIZE_W-1:0] == '0)) ||
                       ((r_e_state == E_PAY) && (r_e_cnt == SIZE_W'(1))));

  always_comb begin
    per_credit_o = '0;
    if (w_e_busy) per_credit_o[r_grant] = noc_credit_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_e_state <= E_ARB;
      r_grant   <= '0;
      r_last    <= GW'(N_PERIPH - 1);
      r_e_cnt   <= '0;
    end else begin
      case (r_e_state)
        E_ARB: if (w_arb_found) begin
          r_grant   <= w_arb_idx;
          r_last    <= w_arb_idx;
          r_e_state <= E_HDR;
        end
        E_HDR: if (w_e_xfer) r_e_state <= E_SIZE;
        E_SIZE: if (w_e_xfer) begin
          r_e_cnt   <= w_e_flit[SIZE_W-1:0];
          r_e_state <= w_e_end ? E_ARB : E_PAY;
        end
        E_PAY: if (w_e_xfer) begin
          r_e_cnt <= r_e_cnt - 1'b1;
          if (w_e_end) r_e_state <= E_ARB;
        end
        default: r_e_state <= E_ARB;
      endcase
    end
  end

  assign w_hdr_t     = noc_data_i[16 +: IDX_W];
  assign w_hdr_tgt   = w_hdr_t[GW-1:0];
  assign w_hdr_valid = (w_hdr_t < NP_IDX);

  // Routing select is forced off in reset; credit keeps following the header rules.
  always_comb begin
    w_i_sel      = '0;
    noc_credit_o = 1'b0;
    if (r_i_state == I_HDR) begin
      if (!w_hdr_valid) begin
        noc_credit_o = 1'b1;
      end else if (w_en[w_hdr_tgt]) begin
        w_i_sel[w_hdr_tgt] = rst_ni;
        noc_credit_o       = per_credit_i[w_hdr_tgt];
      end
    end else if (r_drop) begin
      noc_credit_o = 1'b1;
    end else begin
      w_i_sel[r_tgt] = rst_ni;
      noc_credit_o   = per_credit_i[r_tgt];
    end
  end

  assign per_tx_o = w_i_sel & {N_PERIPH{noc_rx_i}};
  for (genvar gi = 0; gi < N_PERIPH; gi++) begin : g_per_out
    assign per_data_o[gi*FLIT_SIZE +: FLIT_SIZE] = w_i_sel[gi] ? noc_data_i : '0;
  end

  assign w_i_xfer = noc_rx_i & noc_credit_o;
  assign w_i_end  = w_i_xfer &&
                    (((r_i_state == I_SIZE) && (noc_data_i[SIZE_W-1:0] == '0)) ||
                     ((r_i_state == I_PAY) && (r_i_cnt == SIZE_W'(1))));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_i_state <= I_HDR;
      r_tgt     <= '0;
      r_drop    <= 1'b0;
      r_i_cnt   <= '0;
    end else begin
      case (r_i_state)
        I_HDR: if (w_i_xfer) begin
          r_tgt     <= w_hdr_tgt;
          r_drop    <= !w_hdr_valid;
          r_i_state <= I_SIZE;
        end
        I_SIZE: if (w_i_xfer) begin
          r_i_cnt   <= noc_data_i[SIZE_W-1:0];
          r_i_state <= w_i_end ? I_HDR : I_PAY;
        end
        I_PAY: if (w_i_xfer) begin
          r_i_cnt <= r_i_cnt - 1'b1;
          if (w_i_end) r_i_state <= I_HDR;
        end
        default: r_i_state <= I_HDR;
      endcase
    end
  end

  assign egress_state_o  = r_e_state;
  assign ingress_state_o = r_i_state;

`ifdef PERIPH_PORT_STATS_EN
  logic [15:0] r_eg_cnt [N_PERIPH];
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_PERIPH; i++) r_eg_cnt[i] <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_e_end && (r_eg_cnt[r_grant] != 16'hFFFF))
        r_eg_cnt[r_grant] <= r_eg_cnt[r_grant] + 1'b1;
      if (w_i_end && r_drop && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  for (genvar gs = 0; gs < N_PERIPH; gs++) begin : g_stats
    assign egress_pkts_o[gs*16 +: 16] = r_eg_cnt[gs];
  end
  assign drop_pkts_o = r_drop_cnt;
`endif

endmodule
